// File: rtl/gbuff_stream_reader.sv
// Strided burst reader for a single-port global buffer. Returned words are queued in a
// small skid FIFO and presented as a valid/ready stream with a last-word marker.
module gbuff_stream_reader #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              gb_en_o,
  output logic              gb_we_o,
  output logic [ADDR_W-1:0] gb_addr_o,
  input  logic [DATA_W-1:0] gb_rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    popped_q, popped_d;
  logic                inflight_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic [OccW:0]       level, limit;
  logic                issue, push, pop;

  always_comb begin
    valid_o = (occ_q != '0);
    pop     = valid_o & ready_i;
    push    = inflight_q;
    data_o  = mem_q[rd_ptr_q];
    last_o  = valid_o &&
              (({1'b0, popped_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});
    // Reserve a FIFO slot for every read in flight, crediting this cycle's pop.
    level   = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q};
    limit   = (OccW + 1)'(FIFO_DEPTH) + {{OccW{1'b0}}, pop};
    issue   = (state_q == StRun) && (issued_q < len_q) && (level < limit);

    gb_en_o   = issue;
    gb_we_o   = 1'b0;
    gb_addr_o = issue ? addr_q : '0;
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          len_d    = len_i;
          issued_d = '0;
          popped_d = '0;
          state_d  = (len_i == '0) ? StDone : StRun;
        end
      end
      StRun:   if (issued_q == len_q) state_d = StDrain;
      StDrain: state_d = StDrain;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (issue) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + LEN_W'(1);
    end
    if (pop) begin
      popped_d = popped_q + LEN_W'(1);
      if (last_o) state_d = StDone;
    end
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    occ_d    = occ_q + OccW'(push) - OccW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= issue;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      if (push) mem_q[wr_ptr_q] <= gb_rdata_i;
    end
  end

  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (occ_q == OccW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Bench for gbuff_stream_reader: table of directed bursts, reset-abort sequence and
// random bursts checked against an address/data list model with a behavioural SRAM.
module tb_gbuff_stream_reader;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [LW-1:0] len_in = '0;
  logic [AW-1:0] stride_in = '0;
  logic          ready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          busy, done, gb_en, gb_we, valid, last;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] data;

  int n_checks = 0;
  int n_errors = 0;

  gbuff_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_in),
    .len_i(len_in), .stride_i(stride_in), .busy_o(busy), .done_o(done),
    .gb_en_o(gb_en), .gb_we_o(gb_we), .gb_addr_o(gb_addr), .gb_rdata_i(rdata),
    .data_o(data), .valid_o(valid), .ready_i(ready), .last_o(last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // Single-port SRAM, 1-cycle read latency; garbage when not enabled.
  always @(posedge clk) begin
    if (gb_en) rdata <= mem_fn(gb_addr);
    else       rdata <= $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a posedge with the DUT idle.
  task automatic run_burst(input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input logic [AW-1:0] stride, input int mode, input bit poke,
                           input int abort_after, output logic [AW-1:0] first_a,
                           output logic [AW-1:0] last_a, output int n_iss,
                           output int done_cyc);
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] a;
    logic [DW-1:0] sd;
    logic          sl;
    bit            stall, finished, aborted, pop;
    int            np, lastpop, outstanding;
    for (int k = 0; k < int'(len); k++) begin
      a = base + stride * AW'(k);
      exp_addr.push_back(a);
      exp_data.push_back(mem_fn(a));
    end
    first_a = '0; last_a = '0; n_iss = 0; done_cyc = 0;
    np = 0; lastpop = 0; stall = 0; finished = 0; aborted = 0; sd = '0; sl = 1'b0;
    base_in = base; len_in = len; stride_in = stride; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_in = AW'($urandom); len_in = LW'($urandom); stride_in = AW'($urandom);
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (cyc >= 5 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      start = poke && (cyc == 3);
      @(negedge clk);
      check("busy_in_burst", 64'(busy), 64'd1);
      check("we_tied_low", 64'(gb_we), 64'd0);
      pop = valid && ready;
      outstanding = (n_iss + int'(gb_en)) - (np + int'(pop));
      check("occupancy_bound", 64'(outstanding <= int'(DEPTH)), 64'd1);
      if (gb_en) begin
        if (n_iss < int'(len)) check("addr", 64'(gb_addr), 64'(exp_addr[n_iss]));
        else check("extra_issue", 64'(n_iss), 64'(len));
        if (n_iss == 0) begin
          first_a = gb_addr;
          check("first_issue_cycle", 64'(cyc), 64'd1);
        end
        if (mode == 0) check("issue_cycle", 64'(cyc), 64'(n_iss + 1));
        last_a = gb_addr;
        n_iss++;
      end
      if (stall) begin
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_data", 64'(data), 64'(sd));
        check("hold_last", 64'(last), 64'(sl));
      end
      if (pop) begin
        if (np < int'(len)) begin
          check("data", 64'(data), 64'(exp_data[np]));
          check("last", 64'(last), 64'(np == int'(len) - 1));
        end else check("extra_word", 64'(np), 64'(len));
        if (mode == 0) check("pop_cycle", 64'(cyc), 64'(np + 3));
        np++;
        lastpop = cyc;
        if (np == abort_after) begin
          finished = 1;
          aborted = 1;
        end
      end
      stall = valid && !ready;
      sd = data;
      sl = last;
      if (done && !aborted) begin
        check("done_count", 64'(np), 64'(len));
        check("done_timing", 64'(cyc), 64'((len == '0) ? 1 : lastpop + 1));
        done_cyc = cyc;
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      if (!finished) check("burst_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy),    64'd0);
    check({tag, "_done"},  64'(done),    64'd0);
    check({tag, "_en"},    64'(gb_en),   64'd0);
    check({tag, "_we"},    64'(gb_we),   64'd0);
    check({tag, "_valid"}, 64'(valid),   64'd0);
    check({tag, "_last"},  64'(last),    64'd0);
    check({tag, "_addr"},  64'(gb_addr), 64'd0);
    check({tag, "_data"},  64'(data),    64'd0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [AW-1:0] stride;
    int            mode;
    bit            poke;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    int            exp_count;
    int            exp_done;   // 0: timing depends on random ready
  } vec_t;

  vec_t          tbl[7];
  logic [AW-1:0] fa, la;
  int            ni, dc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0010, 16'd4, 16'h0001, 0, 1'b0, 16'h0010, 16'h0013, 4, 7};
    tbl[1] = '{16'h0000, 16'd3, 16'h0004, 0, 1'b0, 16'h0000, 16'h0008, 3, 6};
    tbl[2] = '{16'hFFFE, 16'd3, 16'h0001, 0, 1'b0, 16'hFFFE, 16'h0000, 3, 6};
    tbl[3] = '{16'h0077, 16'd0, 16'h0005, 0, 1'b0, 16'h0000, 16'h0000, 0, 1};
    tbl[4] = '{16'h0100, 16'd8, 16'h0003, 2, 1'b0, 16'h0100, 16'h0115, 8, 0};
    tbl[5] = '{16'h0020, 16'd5, 16'h0002, 0, 1'b1, 16'h0020, 16'h0028, 5, 8};
    tbl[6] = '{16'hFFF0, 16'd6, 16'h0008, 1, 1'b0, 16'hFFF0, 16'h0018, 6, 0};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_burst(tbl[i].base, tbl[i].len, tbl[i].stride, tbl[i].mode, tbl[i].poke, -1,
                fa, la, ni, dc);
      check($sformatf("tbl%0d_count", i), 64'(ni), 64'(tbl[i].exp_count));
      if (tbl[i].exp_count > 0) begin
        check($sformatf("tbl%0d_first", i), 64'(fa), 64'(tbl[i].exp_first));
        check($sformatf("tbl%0d_last", i), 64'(la), 64'(tbl[i].exp_last));
      end
      if (tbl[i].exp_done != 0) check($sformatf("tbl%0d_done", i), 64'(dc), 64'(tbl[i].exp_done));
    end

    // Reset after two of six words, then a clean burst.
    run_burst(16'h0040, 16'd6, 16'h0001, 0, 1'b0, 2, fa, la, ni, dc);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midreset_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst(16'h0010, 16'd4, 16'h0001, 0, 1'b0, -1, fa, la, ni, dc);
    check("post_reset_first", 64'(fa), 64'h10);
    check("post_reset_last", 64'(la), 64'h13);
    check("post_reset_done", 64'(dc), 64'd7);

    for (int r = 0; r < 20; r++) begin
      logic [LW-1:0] rl;
      rl = LW'($urandom_range(1, 12));
      run_burst(AW'($urandom), rl, AW'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                -1, fa, la, ni, dc);
      check("rand_count", 64'(ni), 64'(rl));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
